// File: rtl/axi_stream_input_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_input_pkg
// Shared frame-geometry constants for the AXI-Stream frame receiver.
//   FRAME_CHARS : number of characters collected into one frame (N)
//   CHAR_BITS   : bits per character, equal to the TDATA width (CHAR_LEN)
// State encodings deliberately live inside the receiver, not here.
// ---------------------------------------------------------------------------
package axi_stream_input_pkg;

  localparam int FRAME_CHARS = 8;
  localparam int CHAR_BITS   = 8;

endpackage : axi_stream_input_pkg

// File: rtl/axi_stream_input.sv
// ---------------------------------------------------------------------------
// axi_stream_input
// Collects one frame of N characters from an AXI-Stream slave port into a
// wide register q. A frame is armed by run; the first beat lands in the most
// significant character slot. A short frame (early TLAST) leaves the unused
// low slots at zero; an overlong frame has its extra beats accepted and
// discarded until TLAST. valid is high while the finished frame is presented
// and falls once run has been seen low.
//
// Ports
//   ACLK           in   clock, rising edge
//   ARESETN        in   synchronous active-low reset
//   S_AXIS_TDATA   in   one character per beat (CHAR_LEN bits)
//   S_AXIS_TLAST   in   final beat of a frame
//   S_AXIS_TVALID  in   upstream presents a beat
//   S_AXIS_TREADY  out  receiver accepts a beat (RECV/DROP only)
//   run            in   arm reception of one frame
//   q              out  assembled frame, N*CHAR_LEN bits
//   valid          out  q holds a complete frame
// ---------------------------------------------------------------------------
module axi_stream_input
  import axi_stream_input_pkg::*;
#(
  parameter int N        = FRAME_CHARS,
  parameter int CHAR_LEN = CHAR_BITS
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [CHAR_LEN-1:0]   S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  run,
  output logic [N*CHAR_LEN-1:0] q,
  output logic                  valid
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg,   cnt_next;
  logic [N*CHAR_LEN-1:0] q_reg,     q_next;
  logic                  beat;

  assign S_AXIS_TREADY = (state_reg == RECV) || (state_reg == DROP);
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign q             = q_reg;
  assign valid         = (state_reg == DONE);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;

    case (state_reg)
      IDLE: begin
        // q keeps the previous frame until a new one is armed.
        if (run) begin
          state_next = RECV;
          cnt_next   = '0;
          q_next     = '0;
        end
      end

      RECV: begin
        if (beat) begin
          // Beat k goes to slot N-1-k so the first character is the MSB slot.
          for (int i = 0; i < N; i++) begin
            if (cnt_reg == CNT_W'(N - 1 - i)) begin
              q_next[i*CHAR_LEN +: CHAR_LEN] = S_AXIS_TDATA;
            end
          end
          cnt_next = cnt_reg + CNT_W'(1);
          if (S_AXIS_TLAST) begin
            state_next = DONE;
          end else if (cnt_reg == CNT_W'(N - 1)) begin
            // Frame full but not terminated: swallow the tail.
            state_next = DROP;
          end
        end
      end

      DROP: begin
        if (beat && S_AXIS_TLAST) begin
          state_next = DONE;
        end
      end

      DONE: begin
        // Stay here while run is still high so one arm yields one frame.
        if (!run) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule : axi_stream_input

// File: tb/tb_axi_stream_input.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_input
// Randomised frame stimulus with a queue-based scoreboard. The driver pushes
// the expected frame and beat count for every frame it sends; a monitor pops
// and compares whenever valid rises.
// ---------------------------------------------------------------------------
module tb_axi_stream_input;
  import axi_stream_input_pkg::*;

  localparam int N  = FRAME_CHARS;
  localparam int CL = CHAR_BITS;
  localparam int QW = N * CL;

  typedef struct {
    logic [QW-1:0] frame;
    int            beats;
  } exp_t;

  logic          clk;
  logic          aresetn;
  logic [CL-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          run;
  logic [QW-1:0] q;
  logic          valid;

  int   checks;
  int   errors;
  exp_t sb[$];
  logic [CL-1:0] stim[$];
  int   acc_beats;
  logic valid_prev;

  axi_stream_input dut (
    .ACLK          (clk),
    .ARESETN       (aresetn),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .run           (run),
    .q             (q),
    .valid         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the
  // falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame ends at the last beat; beat k sits k characters below
  // the top; beats beyond N are discarded.
  function automatic logic [QW-1:0] model_frame(input int len);
    logic [QW-1:0] r;
    r = '0;
    for (int k = 0; k < len && k < N; k++) begin
      r = r | ({{(QW-CL){1'b0}}, stim[k]} << ((N - 1 - k) * CL));
    end
    return r;
  endfunction

  task automatic do_frame(input bit gaps, input bit drop_run_early);
    int            len;
    exp_t          e;
    len     = stim.size();
    e.frame = model_frame(len);
    e.beats = len;
    sb.push_back(e);
    $display("frame: len=%0d gaps=%0d early_run_drop=%0d expect q=%h", len, gaps, drop_run_early, e.frame);

    tvalid = 1'b0;
    run    = 1'b1;
    @(negedge clk);
    chk("ready_in_idle", {63'd0, tready}, 64'd0);
    tick();

    for (int k = 0; k < len; k++) begin
      if (gaps) begin
        int n_gap;
        n_gap = $urandom_range(0, 2);
        for (int g = 0; g < n_gap; g++) begin
          tvalid = 1'b0;
          tdata  = CL'($urandom);
          tlast  = 1'($urandom);
          @(negedge clk);
          chk("ready_in_gap", {63'd0, tready}, 64'd1);
          tick();
        end
      end
      tvalid = 1'b1;
      tdata  = stim[k];
      tlast  = (k == len - 1);
      if (drop_run_early && k == 0) run = 1'b0;
      @(negedge clk);
      chk("ready_on_beat", {63'd0, tready}, 64'd1);
      chk("valid_low_in_frame", {63'd0, valid}, 64'd0);
      tick();
    end

    // Junk offered while the frame is presented must not be taken.
    tvalid = 1'b1;
    tdata  = CL'($urandom);
    tlast  = 1'b1;
    @(negedge clk);
    chk("valid_latency1", {63'd0, valid}, 64'd1);
    chk("ready_in_done", {63'd0, tready}, 64'd0);

    if (!drop_run_early) begin
      tick();
      tick();
      @(negedge clk);
      chk("done_hold_valid", {63'd0, valid}, 64'd1);
      chk("done_hold_ready", {63'd0, tready}, 64'd0);
      chk("done_hold_q", q, e.frame);
      tick();
      run = 1'b0;
      @(negedge clk);
      chk("valid_until_run_seen", {63'd0, valid}, 64'd1);
    end
    tick();
    @(negedge clk);
    chk("valid_fall", {63'd0, valid}, 64'd0);
    chk("ready_idle_after", {63'd0, tready}, 64'd0);
    chk("q_hold_idle", q, e.frame);
    tick();
    tvalid = 1'b0;
  endtask

  task automatic make_stim(input int len, input int mode);
    stim.delete();
    for (int k = 0; k < len; k++) begin
      case (mode)
        0:       stim.push_back((k == 0) ? CL'(8'hff) : CL'(8'h01));
        1:       stim.push_back(CL'(8'h33));
        default: stim.push_back(CL'($urandom));
      endcase
    end
  endtask

  // Monitor: scoreboard pop on each rising valid, beat counting on handshakes.
  always @(negedge clk) begin
    if (!aresetn) begin
      acc_beats = 0;
    end else begin
      if (valid && !valid_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got q=%h expected no frame", q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_q", q, e.frame);
          chk("beat_count", QW'(acc_beats), QW'(e.beats));
          $display("observed frame q=%h beats=%0d", q, acc_beats);
        end
        acc_beats = 0;
      end
      if (tvalid && tready) acc_beats++;
    end
    valid_prev = valid;
  end

  initial begin
    checks     = 0;
    errors     = 0;
    acc_beats  = 0;
    valid_prev = 1'b0;
    aresetn    = 1'b0;
    run        = 1'b0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    tdata      = '0;

    tick();
    tick();
    @(negedge clk);
    chk("reset_q", q, '0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_ready", {63'd0, tready}, 64'd0);
    tick();
    aresetn = 1'b1;

    // Idle gating: offered beats with run low go nowhere.
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1;
      tdata  = CL'($urandom);
      tlast  = 1'($urandom);
      @(negedge clk);
      chk("idle_ready", {63'd0, tready}, 64'd0);
      chk("idle_q", q, '0);
      tick();
    end
    tvalid = 1'b0;

    make_stim(N, 0);     do_frame(1'b0, 1'b0);  // nominal
    make_stim(N, 0);     do_frame(1'b1, 1'b0);  // same frame with gaps
    stim.delete();
    stim.push_back(CL'(8'h11));
    stim.push_back(CL'(8'h22));
    do_frame(1'b0, 1'b0);                        // early TLAST
    make_stim(N + 2, 1); do_frame(1'b1, 1'b0);  // overlong
    make_stim(N, 2);     do_frame(1'b1, 1'b1);  // run dropped mid-frame
    for (int f = 0; f < 10; f++) begin
      make_stim($urandom_range(1, N + 3), 2);
      do_frame(1'($urandom), 1'b0);
    end

    // Reset mid-frame after two beats.
    run = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tvalid = 1'b1;
      tdata  = CL'($urandom);
      tlast  = 1'b0;
      tick();
    end
    tvalid  = 1'b0;
    run     = 1'b0;
    aresetn = 1'b0;
    tick();
    @(negedge clk);
    chk("midreset_q", q, '0);
    chk("midreset_valid", {63'd0, valid}, 64'd0);
    chk("midreset_ready", {63'd0, tready}, 64'd0);
    tick();
    aresetn = 1'b1;
    make_stim(N, 2);     do_frame(1'b1, 1'b0);  // fresh frame after reset

    repeat (3) tick();
    @(negedge clk);
    chk("scoreboard_drained", QW'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_axi_stream_input
